bus_vr_arbiter: RTL and testbench
=================================

BUS_VR_ARBITER -- requirements
Module: bus_vr_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, payload width in bits.
REQ-002 SHALL have parameter N, default 4, number of requesters, legal range 1..16.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port valid_i  input  N  per-requester valid.
REQ-006 SHALL have port data_i  input  N*WIDTH  requester k payload in bits [k*WIDTH +: WIDTH].
REQ-007 SHALL have port last_i  input  N  per-requester end-of-packet marker.
REQ-008 SHALL have port ready_o  output  N  per-requester ready, combinational.
REQ-009 SHALL have port valid_o  output  1  registered downstream valid.
REQ-010 SHALL have port data_o  output  WIDTH  registered downstream payload.
REQ-011 SHALL have port id_o  output  max(1,clog2(N))  registered source index of the current beat.
REQ-012 SHALL have port last_o  output  1  registered copy of last_i for the current beat.
REQ-013 SHALL have port ready_i  input  1  downstream ready.

Function
REQ-014 SHALL compute dn_active = ~valid_o | ready_i; the output register loads only when dn_active is 1.
REQ-015 SHALL have FSM states ARB (no packet open) and LOCK (packet open, owner register holds its index).
REQ-016 In ARB, the winner SHALL be the first requester with valid_i=1, scanning ptr, ptr+1, ... mod N.
REQ-017 ready_o SHALL be dn_active for the winner in ARB or the owner in LOCK, and 0 for all other requesters.
REQ-018 A beat SHALL be accepted when valid_i[k] & ready_o[k]; on acceptance data_o, id_o=k, last_o=last_i[k] load and valid_o goes 1 on the next edge.
REQ-019 When dn_active=1 and no beat is accepted, valid_o SHALL go 0; data_o, id_o and last_o SHALL hold.
REQ-020 When dn_active=0, all outputs SHALL hold and every ready_o bit SHALL be 0.
REQ-021 ARB, beat accepted with last_i=0: SHALL enter LOCK with owner=k; ptr holds.
REQ-022 ARB, beat accepted with last_i=1: SHALL stay in ARB and set ptr=(k+1) mod N (single-beat packet).
REQ-023 LOCK, owner beat accepted with last_i=1: SHALL return to ARB and set ptr=(owner+1) mod N.
REQ-024 LOCK: owner deasserting valid_i SHALL NOT release the lock; other requesters stay stalled.
REQ-025 Throughput SHALL be one beat per cycle while ready_i=1; latency is 1 cycle from acceptance to valid_o.
REQ-026 ptr wrap: N-1 SHALL increment to 0; for N=1, ptr and id_o SHALL stay 0.
REQ-027 Each requester SHALL be served at least once within N packets of asserting valid_i (starvation bound).

Reset
REQ-028 Assertion of rst_n=0 SHALL immediately force valid_o=0, data_o=0, id_o=0, last_o=0, state=ARB, ptr=0, owner=0, independent of clk.
REQ-029 While rst_n=0, ready_o SHALL be all 0.
REQ-030 Reset mid-packet SHALL discard the open lock; the first grant after deassertion SHALL follow REQ-016 from ptr=0.

Structure
REQ-031 Package bus_arb_pkg SHALL hold the state enum (ARB, LOCK) and the index-width function max(1,clog2(N)).
REQ-032 The rotating priority pick SHALL be the sub-module bus_rr_pick (inputs req[N] and ptr; outputs gnt_valid and gnt_idx), purely combinational.
REQ-033 The FSM, ptr, owner and output register SHALL live in bus_vr_arbiter; the target size is 120-400 lines.

Verification (N=4, WIDTH=32)
REQ-034 Requester 2 single beat 0xA5A5A5A5, last=1, ready_i=1 -> next cycle valid_o=1, data_o=0xA5A5A5A5, id_o=2, last_o=1; then ptr=3.
REQ-035 All valid_i=1111 with last=1 and ready_i=1 for 8 cycles -> id_o sequence 0,1,2,3,0,1,2,3 with valid_o continuously 1.
REQ-036 Requester 1 sends a 3-beat packet (last on beat 3) while requester 0 is valid -> ready_o[0]=0 until the beat-3 acceptance; next id_o values are 1,1,1,2 or later, with requester 0 served after 3.
REQ-037 Output valid with ready_i=0 held 5 cycles -> data_o, id_o and valid_o stable; ready_o=0000; on ready_i=1, the held beat drains and the next beat loads the same cycle.
REQ-038 rst_n pulsed low during LOCK (owner 3, beat 2 of 4) -> valid_o=0 immediately; after release, with valid_i=1001, the first grant goes to requester 0.
REQ-039 N=1 build: 10 back-to-back beats with last=1 -> all accepted at one per cycle, id_o=0 throughout.

Source files
------------

// File: rtl/bus_arb_pkg.sv
// Shared types and helpers for the valid/ready packet arbiter.
// Holds the arbitration state encoding and the index-width rule.
package bus_arb_pkg;

    typedef enum logic [0:0] {
        ARB  = 1'b0,
        LOCK = 1'b1
    } arb_state_e;

    // A single requester still needs a one-bit index.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bus_rr_pick.sv
// Rotating-priority picker: the first asserted request found by scanning
// ptr, ptr+1, ... modulo N. Purely combinational.
import bus_arb_pkg::*;

module bus_rr_pick #(
    parameter  int N  = 4,
    localparam int IW = idx_width(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic          gnt_valid_o,
    output logic [IW-1:0] gnt_idx_o
);

    logic [IW-1:0] cand_s;
    logic [N-1:0]  req_sh_s;

    function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        return (sum >= N) ? IW'(sum - N) : IW'(sum);
    endfunction

    // Scan from the farthest offset down so the offset closest to ptr wins.
    always_comb begin
        gnt_valid_o = 1'b0;
        gnt_idx_o   = '0;
        cand_s      = '0;
        req_sh_s    = '0;
        for (int off = N - 1; off >= 0; off--) begin
            cand_s   = wrap_add(ptr_i, off);
            req_sh_s = req_i >> cand_s;
            if (req_sh_s[0]) begin
                gnt_valid_o = 1'b1;
                gnt_idx_o   = cand_s;
            end else begin
                gnt_valid_o = gnt_valid_o;
                gnt_idx_o   = gnt_idx_o;
            end
        end
    end

endmodule

// File: rtl/bus_vr_arbiter.sv
// N-to-1 valid/ready packet arbiter: round-robin between packets, locked
// to one owner until its last beat, with a single registered output stage.
import bus_arb_pkg::*;

module bus_vr_arbiter #(
    parameter  int WIDTH = 32,
    parameter  int N     = 4,
    localparam int IW    = idx_width(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N-1:0]       valid_i,
    input  logic [N*WIDTH-1:0] data_i,
    input  logic [N-1:0]       last_i,
    output logic [N-1:0]       ready_o,
    output logic               valid_o,
    output logic [WIDTH-1:0]   data_o,
    output logic [IW-1:0]      id_o,
    output logic               last_o,
    input  logic               ready_i
);

    arb_state_e       state_q, state_d;
    logic [IW-1:0]    ptr_q, ptr_d;
    logic [IW-1:0]    owner_q, owner_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [IW-1:0]    id_q, id_d;
    logic             last_q, last_d;

    logic             dn_active_s;
    logic             gnt_valid_s;
    logic [IW-1:0]    gnt_idx_s;
    logic [IW-1:0]    sel_idx_s;
    logic             sel_ok_s;
    logic             sel_valid_s;
    logic             sel_last_s;
    logic [WIDTH-1:0] sel_data_s;
    logic [IW-1:0]    ptr_inc_s;
    logic             accept_s;
    logic [N-1:0]       valid_sh_s;
    logic [N-1:0]       last_sh_s;
    logic [N*WIDTH-1:0] data_sh_s;

    bus_rr_pick #(
        .N (N)
    ) u_pick (
        .req_i       (valid_i),
        .ptr_i       (ptr_q),
        .gnt_valid_o (gnt_valid_s),
        .gnt_idx_o   (gnt_idx_s)
    );

    // Select the single requester allowed to move this cycle: the owner while
    // a packet is open, otherwise the round-robin winner.
    always_comb begin
        dn_active_s = ~valid_q | ready_i;
        sel_idx_s   = (state_q == LOCK) ? owner_q : gnt_idx_s;
        sel_ok_s    = (state_q == LOCK) | gnt_valid_s;
        valid_sh_s  = valid_i >> sel_idx_s;
        last_sh_s   = last_i >> sel_idx_s;
        data_sh_s   = data_i >> (int'(sel_idx_s) * WIDTH);
        sel_valid_s = valid_sh_s[0];
        sel_last_s  = last_sh_s[0];
        sel_data_s  = data_sh_s[WIDTH-1:0];
        ptr_inc_s   = (int'(sel_idx_s) >= N - 1) ? '0 : sel_idx_s + IW'(1);
        accept_s    = sel_ok_s & dn_active_s & sel_valid_s;
        if (rst_n && dn_active_s && sel_ok_s) begin
            ready_o = N'(1'b1) << sel_idx_s;
        end else begin
            ready_o = '0;
        end
    end

    // Next-state: the output stage loads only when it is empty or draining;
    // the lock opens on a non-last beat and closes on the owner's last beat.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        valid_d = valid_q;
        data_d  = data_q;
        id_d    = id_q;
        last_d  = last_q;
        if (dn_active_s) begin
            valid_d = accept_s;
            if (accept_s) begin
                data_d = sel_data_s;
                id_d   = sel_idx_s;
                last_d = sel_last_s;
                case (state_q)
                    ARB: begin
                        if (sel_last_s) begin
                            ptr_d = ptr_inc_s;
                        end else begin
                            state_d = LOCK;
                            owner_d = sel_idx_s;
                        end
                    end
                    LOCK: begin
                        if (sel_last_s) begin
                            state_d = ARB;
                            ptr_d   = ptr_inc_s;
                        end else begin
                            state_d = LOCK;
                        end
                    end
                    default: begin
                        state_d = ARB;
                    end
                endcase
            end else begin
                data_d = data_q;
            end
        end else begin
            valid_d = valid_q;
        end
    end

    // Arbitration state and the registered output beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ARB;
            ptr_q   <= '0;
            owner_q <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            id_q    <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            id_q    <= id_d;
            last_q  <= last_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign id_o    = id_q;
    assign last_o  = last_q;

endmodule

// File: tb/tb_bus_vr_arbiter.sv
// Self-checking bench for bus_vr_arbiter: directed vector table, multi-cycle
// stall/reset sequences, an N=1 build, and randomized traffic vs a model.
module tb_bus_vr_arbiter;

    localparam int N = 4;
    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic [N-1:0]   valid_i = '0;
    logic [N*W-1:0] data_i = '0;
    logic [N-1:0]   last_i = '0;
    logic           ready_i = 1'b0;
    logic [N-1:0]   ready_o;
    logic           valid_o;
    logic [W-1:0]   data_o;
    logic [1:0]     id_o;
    logic           last_o;

    logic           v1_valid = 1'b0;
    logic [W-1:0]   v1_data = '0;
    logic           v1_last = 1'b0;
    logic           v1_ready_i = 1'b0;
    logic           v1_ready_o;
    logic           v1_valid_o;
    logic [W-1:0]   v1_data_o;
    logic [0:0]     v1_id_o;
    logic           v1_last_o;

    int n_checks = 0;
    int n_errors = 0;

    bus_vr_arbiter #(.WIDTH(W), .N(N)) dut (
        .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .data_i(data_i), .last_i(last_i),
        .ready_o(ready_o), .valid_o(valid_o), .data_o(data_o), .id_o(id_o),
        .last_o(last_o), .ready_i(ready_i)
    );

    bus_vr_arbiter #(.WIDTH(W), .N(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .valid_i(v1_valid), .data_i(v1_data), .last_i(v1_last),
        .ready_o(v1_ready_o), .valid_o(v1_valid_o), .data_o(v1_data_o), .id_o(v1_id_o),
        .last_o(v1_last_o), .ready_i(v1_ready_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] v;
        logic [3:0] l;
        logic       rdy;
        logic [3:0] er;
        logic       evo;
        int         eid;
        logic       el;
    } vec_t;

    vec_t tbl[$];

    // Reference model state (abstract: integers and flags)
    bit          m_vo;
    bit          m_lock;
    bit          m_last;
    int          m_ptr;
    int          m_owner;
    int          m_id;
    logic [31:0] m_data;

    function automatic logic [31:0] pay(input int k);
        return 32'hA5A5A5A5 + 32'(k) - 32'd2;
    endfunction

    function automatic logic bit_of(input logic [3:0] vec, input int idx);
        logic [3:0] t;
        t = vec >> idx;
        return t[0];
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic [3:0] v, input logic [3:0] l, input logic rdy,
                       input logic [3:0] er, input logic evo, input int eid, input logic el);
        vec_t r;
        r.v = v; r.l = l; r.rdy = rdy; r.er = er; r.evo = evo; r.eid = eid; r.el = el;
        tbl.push_back(r);
    endtask

    task automatic apply(input logic [3:0] v, input logic [3:0] l, input logic rdy,
                         input logic [3:0] er, input logic evo, input int eid,
                         input logic el, input string tag);
        @(negedge clk);
        valid_i = v;
        last_i  = l;
        ready_i = rdy;
        #1;
        check({tag, " ready_o"}, 64'(ready_o), 64'(er));
        @(posedge clk);
        #1;
        check({tag, " valid_o"}, 64'(valid_o), 64'(evo));
        check({tag, " id_o"}, 64'(id_o), 64'(eid));
        check({tag, " last_o"}, 64'(last_o), 64'(el));
        check({tag, " data_o"}, 64'(data_o), 64'(pay(eid)));
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        valid_i  = 4'hF;
        ready_i  = 1'b1;
        v1_valid = 1'b1;
        #1;
        check("rst valid_o", 64'(valid_o), 64'd0);
        check("rst data_o", 64'(data_o), 64'd0);
        check("rst id_o", 64'(id_o), 64'd0);
        check("rst last_o", 64'(last_o), 64'd0);
        @(negedge clk);
        check("rst ready_o", 64'(ready_o), 64'd0);
        check("rst n1 ready_o", 64'(v1_ready_o), 64'd0);
        valid_i  = '0;
        last_i   = '0;
        v1_valid = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    // One clock of the reference model: returns expected ready, then advances.
    task automatic model_cycle(output logic [3:0] exp_rdy);
        bit dn;
        bit have;
        int sel;
        logic [127:0] dsh;
        dn   = !m_vo || ready_i;
        have = 1'b0;
        sel  = 0;
        if (m_lock) begin
            have = 1'b1;
            sel  = m_owner;
        end else begin
            for (int o = 0; o < N; o++) begin
                if (!have && bit_of(valid_i, (m_ptr + o) % N)) begin
                    have = 1'b1;
                    sel  = (m_ptr + o) % N;
                end
            end
        end
        exp_rdy = (dn && have) ? 4'(1 << sel) : 4'b0;
        if (dn) begin
            if (have && bit_of(valid_i, sel)) begin
                dsh    = data_i >> (sel * 32);
                m_vo   = 1'b1;
                m_data = dsh[31:0];
                m_id   = sel;
                m_last = bit_of(last_i, sel);
                if (m_last) begin
                    m_lock = 1'b0;
                    m_ptr  = (sel + 1) % N;
                end else begin
                    m_lock  = 1'b1;
                    m_owner = sel;
                end
            end else begin
                m_vo = 1'b0;
            end
        end
    endtask

    initial begin
        logic [3:0] er;
        #1;
        data_i = {pay(3), pay(2), pay(1), pay(0)};
        do_reset();

        // Round robin over all four, then single beats and a locked packet
        for (int i = 0; i < 8; i++) add(4'hF, 4'hF, 1'b1, 4'(1 << (i % 4)), 1'b1, i % 4, 1'b1);
        add(4'h4, 4'hF, 1'b1, 4'h4, 1'b1, 2, 1'b1);
        add(4'h6, 4'hF, 1'b1, 4'h2, 1'b1, 1, 1'b1);
        add(4'h0, 4'h0, 1'b1, 4'h0, 1'b0, 1, 1'b1);
        add(4'h1, 4'hF, 1'b1, 4'h1, 1'b1, 0, 1'b1);
        add(4'h3, 4'h0, 1'b1, 4'h2, 1'b1, 1, 1'b0);
        add(4'h1, 4'h0, 1'b1, 4'h2, 1'b0, 1, 1'b0);
        add(4'h3, 4'h0, 1'b1, 4'h2, 1'b1, 1, 1'b0);
        add(4'h3, 4'h2, 1'b1, 4'h2, 1'b1, 1, 1'b1);
        add(4'h3, 4'hF, 1'b1, 4'h1, 1'b1, 0, 1'b1);
        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i].v, tbl[i].l, tbl[i].rdy, tbl[i].er, tbl[i].evo, tbl[i].eid,
                  tbl[i].el, $sformatf("vec%0d", i));
        end

        // Downstream stall for five cycles, then drain and reload together
        apply(4'h1, 4'hF, 1'b1, 4'h1, 1'b1, 0, 1'b1, "stall load");
        for (int i = 0; i < 5; i++) apply(4'h2, 4'hF, 1'b0, 4'h0, 1'b1, 0, 1'b1, "stall hold");
        apply(4'h2, 4'hF, 1'b1, 4'h2, 1'b1, 1, 1'b1, "stall drain");

        // Reset in the middle of a locked packet owned by requester 3
        apply(4'h8, 4'h0, 1'b1, 4'h8, 1'b1, 3, 1'b0, "lock beat1");
        apply(4'h8, 4'h0, 1'b1, 4'h8, 1'b1, 3, 1'b0, "lock beat2");
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst valid_o", 64'(valid_o), 64'd0);
        check("midrst data_o", 64'(data_o), 64'd0);
        check("midrst id_o", 64'(id_o), 64'd0);
        check("midrst ready_o", 64'(ready_o), 64'd0);
        #4;
        rst_n = 1'b1;
        apply(4'h9, 4'h9, 1'b1, 4'h1, 1'b1, 0, 1'b1, "post rst");

        // Single-requester build
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            v1_valid   = 1'b1;
            v1_last    = 1'b1;
            v1_ready_i = 1'b1;
            v1_data    = 32'h100 + 32'(i);
            #1;
            check("n1 ready_o", 64'(v1_ready_o), 64'd1);
            @(posedge clk);
            #1;
            check("n1 valid_o", 64'(v1_valid_o), 64'd1);
            check("n1 id_o", 64'(v1_id_o), 64'd0);
            check("n1 data_o", 64'(v1_data_o), 64'(32'h100 + 32'(i)));
        end
        @(negedge clk);
        v1_valid = 1'b0;
        @(posedge clk);
        #1;
        check("n1 idle valid_o", 64'(v1_valid_o), 64'd0);

        // Randomized traffic against the reference model
        do_reset();
        m_vo = 1'b0; m_lock = 1'b0; m_last = 1'b0;
        m_ptr = 0; m_owner = 0; m_id = 0; m_data = '0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            check("rnd valid_o", 64'(valid_o), 64'(m_vo));
            check("rnd id_o", 64'(id_o), 64'(m_id));
            check("rnd last_o", 64'(last_o), 64'(m_last));
            check("rnd data_o", 64'(data_o), 64'(m_data));
            valid_i = 4'($urandom);
            last_i  = 4'($urandom) | 4'($urandom);
            ready_i = ($urandom_range(0, 3) != 0);
            data_i  = {$urandom, $urandom, $urandom, $urandom};
            #1;
            model_cycle(er);
            check("rnd ready_o", 64'(ready_o), 64'(er));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
